// File: rtl/a_ref_cal_pkg.sv
// Shared types and constants for the ring-oscillator reference calibration controller.
// Optional tracking mode in DONE is enabled by defining REF_CAL_TRACK_EN.
package a_ref_cal_pkg;

  localparam int DLY_W = 9;
  localparam int IDX_W = 4;
  localparam logic [DLY_W-1:0] SAR_START = 9'h100;
  localparam logic [DLY_W-1:0] DLY_MAX   = 9'h1FF;
  localparam logic [IDX_W-1:0] IDX_TOP   = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEAS,
    ST_CMP,
    ST_DONE
  } state_t;

  // One tracking step on the delay code, clamped at both ends of the range.
  function automatic logic [DLY_W-1:0] sat_step(input logic [DLY_W-1:0] code,
                                                input logic up, input logic dn);
    logic [DLY_W-1:0] res;
    res = code;
    if (up && code != DLY_MAX) res = code + 1'b1;
    else if (dn && code != '0) res = code - 1'b1;
    return res;
  endfunction

endpackage

// File: rtl/a_ref_cal_cnt.sv
// Oscillator edge counter: 2-flop synchronizer, rising-edge detect on the synchronized
// signal, and a saturating counter with synchronous clear and count enable.
module a_ref_cal_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_osc,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);

  // osc_sync[1:0] is the synchronizer; osc_sync[2] is the previous synchronized value.
  logic [2:0] osc_sync;
  logic       rise;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) osc_sync <= '0;
    else         osc_sync <= {osc_sync[1:0], i_osc};
  end

  assign rise = osc_sync[1] & ~osc_sync[2];

  always_ff @(posedge i_clk) begin
    if (!i_rstn || i_clr)                o_cnt <= '0;
    else if (i_en && rise && o_cnt != '1) o_cnt <= o_cnt + 1'b1;
  end

endmodule

// File: rtl/a_ref_cal.sv
// SAR calibration of the ring-oscillator delay code against a target edge count per window.
// Define REF_CAL_TRACK_EN to keep re-measuring in DONE and nudge the code by +/-1 per window.
//
//  state  | meaning
//  IDLE   | waiting for i_start after reset
//  SETTLE | ring settling after a code change, edge counter held at 0
//  MEAS   | counting synchronized osc edges for WIN_CYC cycles
//  CMP    | latch count, decide current bit (or track step)
//  DONE   | code valid; static, or tracking when REF_CAL_TRACK_EN
module a_ref_cal
  import a_ref_cal_pkg::*;
#(
  parameter int WIN_CYC    = 1024,
  parameter int SETTLE_CYC = 32,
  parameter int CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_osc,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_target,
  output logic [DLY_W-1:0] o_dly_sel,
  output logic             o_mode,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [CNT_W-1:0] o_cnt
);

  localparam int TMR_MAX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam logic [TMR_W-1:0] WIN_LOAD    = TMR_W'(WIN_CYC - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [DLY_W-1:0] dly_nxt, sar;
  logic             mode_nxt, busy_nxt, done_nxt, err_nxt;
  logic [CNT_W-1:0] cnt_out_nxt;
  logic             trk, trk_nxt;
  logic             start_ok;
  logic             cnt_clr, cnt_en;
  logic [CNT_W-1:0] cnt;

  a_ref_cal_cnt #(.CNT_W(CNT_W)) u_cnt (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_osc  (i_osc),
    .i_clr  (cnt_clr),
    .i_en   (cnt_en),
    .o_cnt  (cnt)
  );

  // While tracking, the FSM loops SETTLE/MEAS/CMP but is logically still in DONE.
  assign start_ok = i_start && (state == ST_IDLE || state == ST_DONE || trk);

  always_comb begin
    state_nxt   = state;
    timer_nxt   = (timer != '0) ? timer - 1'b1 : timer;
    idx_nxt     = idx;
    dly_nxt     = o_dly_sel;
    mode_nxt    = o_mode;
    busy_nxt    = o_busy;
    done_nxt    = o_done;
    err_nxt     = o_err;
    cnt_out_nxt = o_cnt;
    trk_nxt     = trk;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    sar         = o_dly_sel;

    case (state)
      ST_SETTLE: begin
        cnt_clr = 1'b1;
        if (timer == '0) begin
          state_nxt = ST_MEAS;
          timer_nxt = WIN_LOAD;
        end
      end
      ST_MEAS: begin
        cnt_en = 1'b1;
        if (timer == '0) state_nxt = ST_CMP;
      end
      ST_CMP: begin
        cnt_out_nxt = cnt;
        if (trk) begin
`ifdef REF_CAL_TRACK_EN
          dly_nxt = sat_step(o_dly_sel, cnt > i_target, cnt < i_target);
          err_nxt = (dly_nxt == DLY_MAX);
`endif
          state_nxt = ST_SETTLE;
          timer_nxt = SETTLE_LOAD;
        end else begin
          // count > target: ring too fast at this code, keep the bit
          if (!(cnt > i_target)) sar[idx] = 1'b0;
          if (idx != '0) begin
            sar[idx - 1'b1] = 1'b1;
            idx_nxt   = idx - 1'b1;
            state_nxt = ST_SETTLE;
            timer_nxt = SETTLE_LOAD;
          end else begin
            state_nxt = ST_DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            err_nxt   = (sar == DLY_MAX);
          end
          dly_nxt = sar;
        end
      end
      ST_DONE: begin
`ifdef REF_CAL_TRACK_EN
        trk_nxt   = 1'b1;
        state_nxt = ST_SETTLE;
        timer_nxt = SETTLE_LOAD;
`endif
      end
      default: ;
    endcase

    if (start_ok) begin
      state_nxt = ST_SETTLE;
      timer_nxt = SETTLE_LOAD;
      idx_nxt   = IDX_TOP;
      dly_nxt   = SAR_START;
      mode_nxt  = 1'b1;
      busy_nxt  = 1'b1;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      trk_nxt   = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state     <= ST_IDLE;
      timer     <= '0;
      idx       <= '0;
      o_dly_sel <= '0;
      o_mode    <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      o_cnt     <= '0;
      trk       <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      idx       <= idx_nxt;
      o_dly_sel <= dly_nxt;
      o_mode    <= mode_nxt;
      o_busy    <= busy_nxt;
      o_done    <= done_nxt;
      o_err     <= err_nxt;
      o_cnt     <= cnt_out_nxt;
      trk       <= trk_nxt;
    end
  end

endmodule

// File: tb/tb_a_ref_cal.sv
// Bench for a_ref_cal: behavioural ring-oscillator model (period = base + o_dly_sel clocks)
// and a scoreboard of expected SAR results derived from that model.
`timescale 1ns/1ps
module tb_a_ref_cal;

  localparam int WIN     = 1024;
  localparam int STEP    = 32 + 1024 + 1;
  localparam int LAT     = 9 * STEP;
  localparam int BUDGET  = LAT + 3000;

  typedef struct {
    logic [8:0] dly;
    logic       err;
    int         cnt_lo;
    int         cnt_hi;
  } exp_t;

  exp_t sb_q[$];

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        osc, osc8;
  logic        start = 1'b0, start8 = 1'b0;
  logic [15:0] target = '0;
  logic [7:0]  target8 = 8'hFF;
  logic [8:0]  dly_sel, dly_sel8;
  logic        mode, busy, done, err;
  logic        mode8, busy8, done8, err8;
  logic [15:0] cnt;
  logic [7:0]  cnt8;
  int          osc_base = 2;
  int          n_run = 0, n_fail = 0;

  a_ref_cal u_dut (
    .i_clk(clk), .i_rstn(rstn), .i_osc(osc), .i_start(start), .i_target(target),
    .o_dly_sel(dly_sel), .o_mode(mode), .o_busy(busy), .o_done(done), .o_err(err), .o_cnt(cnt)
  );

  a_ref_cal #(.CNT_W(8)) u_dut8 (
    .i_clk(clk), .i_rstn(rstn), .i_osc(osc8), .i_start(start8), .i_target(target8),
    .o_dly_sel(dly_sel8), .o_mode(mode8), .o_busy(busy8), .o_done(done8), .o_err(err8), .o_cnt(cnt8)
  );

  always #5 clk = ~clk;

  initial begin
    int half;
    osc = 1'b0;
    #3;
    forever begin
      half = (osc_base + int'(dly_sel)) * 5;
      #(half);
      osc = ~osc;
    end
  end

  initial begin
    osc8 = 1'b0;
    #7;
    forever #10 osc8 = ~osc8;
  end

  function automatic int model_cnt(input int code, input int base);
    return WIN / (base + code);
  endfunction

  function automatic exp_t sar_model(input int tgt);
    exp_t e;
    int code, trial, last;
    code = 0;
    last = 0;
    for (int b = 8; b >= 0; b--) begin
      trial = code | (1 << b);
      last  = trial;
      if (model_cnt(trial, 2) > tgt) code = trial;
    end
    e.dly    = 9'(code);
    e.err    = (code == 511);
    e.cnt_lo = model_cnt(last, 2) - 1;
    e.cnt_hi = model_cnt(last, 2) + 1;
    return e;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    while (cycles < BUDGET && !ok) begin
      @(posedge clk); #1;
      cycles++;
      if (done) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_run++; if (dly_sel !== 9'h000) begin n_fail++; $display("FAIL reset_dly: got %h expected 000", dly_sel); end
    n_run++; if ({mode, busy, done, err} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {mode, busy, done, err}); end
    n_run++; if (cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_sar_nominal();
    exp_t e;
    int cyc;
    bit ok;
    target = 16'd100;
    sb_q.push_back(sar_model(100));
    pulse_start();
    n_run++; if ({busy, done, mode} !== 3'b101 || dly_sel !== 9'h100) begin
      n_fail++; $display("FAIL accept_state: busy/done/mode %b dly %h expected 101 100", {busy, done, mode}, dly_sel);
    end
    wait_done(cyc, ok);
    e = sb_q.pop_front();
    n_run++; if (!ok || cyc != LAT) begin n_fail++; $display("FAIL nominal_latency: got %0d expected %0d", cyc, LAT); end
    n_run++; if (dly_sel !== e.dly) begin n_fail++; $display("FAIL nominal_code: got %0d expected %0d", dly_sel, e.dly); end
    n_run++; if (err !== e.err || busy !== 1'b0 || mode !== 1'b1) begin
      n_fail++; $display("FAIL nominal_flags: err %b busy %b mode %b expected %b 0 1", err, busy, mode, e.err);
    end
    n_run++; if (int'(cnt) < e.cnt_lo || int'(cnt) > e.cnt_hi) begin
      n_fail++; $display("FAIL nominal_cnt: got %0d expected %0d..%0d", cnt, e.cnt_lo, e.cnt_hi);
    end
  endtask

`ifndef REF_CAL_TRACK_EN
  task automatic test_done_static();
    exp_t e;
    bit moved;
    e = sar_model(100);
    moved = 1'b0;
    repeat (2 * STEP) begin
      @(posedge clk); #1;
      if (dly_sel !== e.dly || done !== 1'b1 || busy !== 1'b0 ||
          int'(cnt) < e.cnt_lo || int'(cnt) > e.cnt_hi) moved = 1'b1;
    end
    n_run++; if (moved) begin n_fail++; $display("FAIL done_static: outputs changed, dly %0d cnt %0d done %b expected dly %0d", dly_sel, cnt, done, e.dly); end
  endtask
`else
  task automatic test_track();
    int seq_exp[2];
    int prev;
    int n;
    bit bad;
    seq_exp[0] = 7;
    seq_exp[1] = 6;
    osc_base = 4;
    for (int s = 0; s < 2; s++) begin
      prev = int'(dly_sel);
      n = 0;
      while (int'(dly_sel) == prev && n < STEP + 200) begin
        @(posedge clk); #1;
        n++;
      end
      n_run++; if (int'(dly_sel) != seq_exp[s] || done !== 1'b1 || busy !== 1'b0) begin
        n_fail++; $display("FAIL track_step%0d: got %0d done %b after %0d cycles expected %0d", s, dly_sel, done, n, seq_exp[s]);
      end
    end
    bad = 1'b0;
    repeat (4 * STEP) begin
      @(posedge clk); #1;
      if (done !== 1'b1 || !(dly_sel == 9'd6 || dly_sel == 9'd7)) bad = 1'b1;
    end
    n_run++; if (bad) begin n_fail++; $display("FAIL track_equilibrium: got dly %0d done %b expected 6/7 with done 1", dly_sel, done); end
    osc_base = 2;
  endtask
`endif

  task automatic test_start_ignored();
    exp_t e;
    int cyc, cyc2;
    bit ok;
    target = 16'd100;
    sb_q.push_back(sar_model(100));
    pulse_start();
    repeat (3000) @(posedge clk);
    #1;
    pulse_start();
    n_run++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL mid_start_busy: busy %b done %b expected 1 0", busy, done); end
    wait_done(cyc, ok);
    cyc2 = cyc + 3001;
    e = sb_q.pop_front();
    n_run++; if (!ok || cyc2 != LAT) begin n_fail++; $display("FAIL mid_start_latency: got %0d expected %0d", cyc2, LAT); end
    n_run++; if (dly_sel !== e.dly || err !== e.err) begin n_fail++; $display("FAIL mid_start_code: got %0d/%b expected %0d/%b", dly_sel, err, e.dly, e.err); end
  endtask

  task automatic test_range(input int tgt);
    exp_t e;
    int cyc;
    bit ok;
    target = 16'(tgt);
    sb_q.push_back(sar_model(tgt));
    pulse_start();
    wait_done(cyc, ok);
    e = sb_q.pop_front();
    n_run++; if (!ok) begin n_fail++; $display("FAIL range%0d_timeout: got no done expected done within %0d", tgt, BUDGET); end
    n_run++; if (dly_sel !== e.dly) begin n_fail++; $display("FAIL range%0d_code: got %h expected %h", tgt, dly_sel, e.dly); end
    n_run++; if (err !== e.err || done !== 1'b1) begin n_fail++; $display("FAIL range%0d_err: got err %b done %b expected %b 1", tgt, err, done, e.err); end
    n_run++; if (int'(cnt) > 512 || int'(cnt) < e.cnt_lo || int'(cnt) > e.cnt_hi) begin
      n_fail++; $display("FAIL range%0d_cnt: got %0d expected %0d..%0d", tgt, cnt, e.cnt_lo, e.cnt_hi);
    end
  endtask

  task automatic test_reset_mid_meas();
    bit bad;
    target = 16'd100;
    pulse_start();
    repeat (500) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    n_run++; if (dly_sel !== 9'h000 || {mode, busy, done, err} !== 4'b0000 || cnt !== 16'h0) begin
      n_fail++; $display("FAIL mid_reset: got dly %h flags %b cnt %0d expected 000 0000 0", dly_sel, {mode, busy, done, err}, cnt);
    end
    rstn = 1'b1;
    bad = 1'b0;
    repeat (200) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || mode !== 1'b0 || dly_sel !== 9'h000) bad = 1'b1;
    end
    n_run++; if (bad) begin n_fail++; $display("FAIL mid_reset_idle: got busy %b mode %b dly %h expected idle", busy, mode, dly_sel); end
  endtask

  task automatic test_cnt_sat();
    exp_t e;
    int n;
    e.dly = 9'h000;
    e.err = 1'b0;
    e.cnt_lo = 255;
    e.cnt_hi = 255;
    sb_q.push_back(e);
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
    end
    e = sb_q.pop_front();
    n_run++; if (done8 !== 1'b1) begin n_fail++; $display("FAIL sat_timeout: got done %b expected 1", done8); end
    n_run++; if (int'(cnt8) != e.cnt_lo) begin n_fail++; $display("FAIL sat_cnt: got %h expected %h", cnt8, e.cnt_lo); end
    n_run++; if (dly_sel8 !== e.dly || err8 !== e.err) begin n_fail++; $display("FAIL sat_code: got %h/%b expected %h/%b", dly_sel8, err8, e.dly, e.err); end
  endtask

  initial begin
    test_reset();
    test_sar_nominal();
`ifndef REF_CAL_TRACK_EN
    test_done_static();
`else
    test_track();
`endif
    test_start_ignored();
    test_range(0);
    test_range(600);
    test_reset_mid_meas();
    test_cnt_sat();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
